mul_div_iter: RTL and testbench

- Iterative multiply/divide unit directly downstream of the register bank: consumes the two read operands (DR1 → op_a, DR2 → op_b) for MULT/MULTU/DIV/DIVU.
- Holds results in architectural HI/LO registers. The writeback mux returns them to the bank's DataIn on MFHI/MFLO.
- Multicycle with a start/busy/done handshake; the control unit stalls while busy=1.

---
 rtl/mul_div_iter.sv | 150 +++++++++++++++
 tb/tb_mul_div_iter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_iter.sv
`default_nettype none
// ============================================================================
// Module : mul_div_iter
// Iterative shift-add multiplier / restoring divider feeding HI/LO registers.
// Rev    : 1.0  initial release
// ============================================================================
module mul_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int                 c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_ZERO = 2'd3
  } state_t;

  state_t               r_state;
  logic [2*WIDTH-1:0]   r_prod;   // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]     r_b;      // multiplicand or divisor magnitude
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_div;
  logic                 r_sa;
  logic                 r_sb;

  logic                 w_neg_a;
  logic                 w_neg_b;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [WIDTH:0]       w_msum;
  logic [2*WIDTH:0]     w_dshift;
  logic [WIDTH:0]       w_ddiff;
  logic [2*WIDTH-1:0]   w_prod_neg;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;
  logic [WIDTH-1:0]     w_quo_neg;
  logic [WIDTH-1:0]     w_rem_neg;

  assign w_neg_a    = op[0] & op_a[WIDTH-1];
  assign w_neg_b    = op[0] & op_b[WIDTH-1];
  assign w_abs_a    = w_neg_a ? -op_a : op_a;
  assign w_abs_b    = w_neg_b ? -op_b : op_b;

  assign w_msum     = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_b};
  assign w_dshift   = {r_prod, 1'b0};
  assign w_ddiff    = w_dshift[2*WIDTH:WIDTH] - {1'b0, r_b};

  assign w_prod_neg = -r_prod;
  assign w_quo      = r_prod[WIDTH-1:0];
  assign w_rem      = r_prod[2*WIDTH-1:WIDTH];
  assign w_quo_neg  = -w_quo;
  assign w_rem_neg  = -w_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_prod   <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_div    <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            r_cnt <= '0;
            r_div <= op[1];
            r_sa  <= w_neg_a;
            r_sb  <= w_neg_b;
            if (op[1] && (op_b == '0)) begin
              // Raw dividend is parked here so ZERO can return it on hi.
              r_prod  <= {{WIDTH{1'b0}}, op_a};
              r_state <= S_ZERO;
            end else begin
              r_prod  <= {{WIDTH{1'b0}}, op[1] ? w_abs_a : w_abs_b};
              r_b     <= op[1] ? w_abs_b : w_abs_a;
              r_state <= S_CALC;
            end
          end
        end

        S_CALC: begin
          if (r_div) begin
            // Restoring step: keep the trial subtraction only if it did not borrow.
            if (!w_ddiff[WIDTH])
              r_prod <= {w_ddiff[WIDTH-1:0], w_dshift[WIDTH-1:1], 1'b1};
            else
              r_prod <= w_dshift[2*WIDTH-1:0];
          end else if (r_prod[0]) begin
            r_prod <= {w_msum, r_prod[WIDTH-1:1]};
          end else begin
            r_prod <= {1'b0, r_prod[2*WIDTH-1:1]};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last)
            r_state <= S_FIX;
        end

        S_FIX: begin
          if (r_div) begin
            lo <= (r_sa ^ r_sb) ? w_quo_neg : w_quo;
            hi <= r_sa ? w_rem_neg : w_rem;
          end else begin
            {hi, lo} <= (r_sa ^ r_sb) ? w_prod_neg : r_prod;
          end
          div_zero <= 1'b0;
          done     <= 1'b1;
          busy     <= 1'b0;
          r_state  <= S_IDLE;
        end

        S_ZERO: begin
          hi       <= r_prod[WIDTH-1:0];
          lo       <= '1;
          div_zero <= 1'b1;
          done     <= 1'b1;
          busy     <= 1'b0;
          r_state  <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_div_iter.sv
`default_nettype none
// ============================================================================
// Module : tb_mul_div_iter
// Scoreboard bench for mul_div_iter with a plain-arithmetic reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mul_div_iter;

  localparam int WIDTH = 32;
  localparam int c_lat = WIDTH + 1;

  typedef struct packed {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dz;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  res_t             sb_q[$];
  res_t             mon_e;
  int               n_vec = 0;
  int               n_err = 0;
  logic [WIDTH-1:0] last_hi = '0;
  logic [WIDTH-1:0] last_lo = '0;

  always #5 clk = ~clk;

  mul_div_iter #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  // Reference: 64-bit arithmetic; SV signed '/' and '%' already truncate toward zero.
  function automatic res_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    res_t        r;
    longint      sa, sb, p, q, m;
    logic [63:0] up;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    r.dz = 1'b0;
    if (o == 2'b00) begin
      up = {32'd0, a} * {32'd0, b};
      r.hi = up[63:32]; r.lo = up[31:0];
    end else if (o == 2'b01) begin
      p  = sa * sb;
      up = p;
      r.hi = up[63:32]; r.lo = up[31:0];
    end else if (b == 32'd0) begin
      r.hi = a; r.lo = '1; r.dz = 1'b1;
    end else if (o == 2'b10) begin
      r.lo = a / b; r.hi = a % b;
    end else begin
      q = sa / sb; m = sa % sb;
      r.lo = q[31:0]; r.hi = m[31:0];
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no completion (t=%0t)", $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("hi", hi, mon_e.hi);
        chk("lo", lo, mon_e.lo);
        chk("div_zero", div_zero, mon_e.dz);
        last_hi = mon_e.hi;
        last_lo = mon_e.lo;
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    sb_q.push_back(model(o, a, b));
    op = o; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'($urandom);
    op_a  = $urandom;
    op_b  = $urandom;
  endtask

  // Counts edges after the accepting edge until done; optionally pokes start mid-flight.
  task automatic wait_done(input int exp_n, input bit disturb);
    int n    = 0;
    bit seen = 1'b0;
    while (n < 100 && !seen) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        chk("busy_high", busy, 1);
        chk("hi_held", hi, last_hi);
        chk("lo_held", lo, last_lo);
        start = disturb && (n == 2 || n == 19);
        if (start) begin
          op = 2'($urandom); op_a = $urandom; op_b = $urandom;
        end
      end
    end
    start = 1'b0;
    chk("latency", n, exp_n);
    if (seen) chk("busy_low_on_done", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected completion within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  o;
    logic [31:0] a, b;
    rst_n = 1'b0; start = 1'b0; op = '0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_div_zero", div_zero, 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done(c_lat, 1'b0);
    issue(2'b01, 32'hFFFF_FFFD, 32'd7);         wait_done(c_lat, 1'b0);
    issue(2'b10, 32'd100, 32'd7);               wait_done(c_lat, 1'b0);
    issue(2'b11, 32'hFFFF_FFF9, 32'd2);         wait_done(c_lat, 1'b0);
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF); wait_done(c_lat, 1'b0);
    issue(2'b10, 32'h1234_5678, 32'd0);         wait_done(1, 1'b0);
    issue(2'b00, 32'd2, 32'd3);                 wait_done(c_lat, 1'b0);
    issue(2'b00, 32'd5, 32'd5);                 wait_done(c_lat, 1'b1);

    // Abort a divide with an asynchronous reset.
    issue(2'b11, 32'hDEAD_BEEF, 32'd5);
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    chk("arst_div_zero", div_zero, 0);
    sb_q.delete();
    last_hi = '0;
    last_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(2'b00, 32'd3, 32'd4); wait_done(c_lat, 1'b0);

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        3: b = 32'd1;
        4: b = b >> $urandom_range(1, 31);
        default: ;
      endcase
      issue(o, a, b);
      wait_done((o[1] && b == 32'd0) ? 1 : c_lat, 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
